hist_ram_sink: RTL and testbench

Receive side of the histogram write-command stream. Accepts the 32-bit AXI-Stream command words `{8'h00, addr[7:0], 8'h00, data[7:0]}` produced by the histogram engine and decodes them into byte writes to a local 256-byte RAM. Serves random reads to the top level and, on request, streams the whole RAM back out in the same word format for export.

---
 rtl/hist_ram_sink.sv | 194 +++++++++++++++++++
 tb/tb_hist_ram_sink.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_ram_sink.sv
// Histogram write-command sink: decodes {0,addr,0,data} words into a byte RAM, serves random reads, streams a full dump.
// Latency: command written 1 cycle after acceptance into an empty FIFO; rd_data 1 cycle; dump valid 2 cycles after dump_start.
// Backpressure: s_axis_tready low outside IDLE, while a dump is pending, or with the FIFO full; dump words hold while m_axis_tready is low.

module hist_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_vld,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_vld, pop_vld})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push_vld) store[wr_ptr] <= push_dat;
    end

    assign head_dat = store[rd_ptr];
endmodule

module hist_ram_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    input  logic [7:0]  rd_addr,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    input  logic        dump_start,
    output logic        busy,
    output logic [7:0]  err_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] LAST_ADDR = 8'(MEM_DEPTH - 1);

    typedef struct packed {
        logic [7:0] pad_hi;
        logic [7:0] addr;
        logic [7:0] pad_lo;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic [1:0] {CLEAR, IDLE, DRAIN, DUMP} state_t;

    state_t        state;
    logic [7:0]    clear_ptr;
    logic [7:0]    dump_ptr;
    logic          dump_pend;
    logic [7:0]    mem [MEM_DEPTH];

    cmd_t          in_cmd;
    cmd_t          head_cmd;
    logic [CW-1:0] fifo_count;
    logic          push_vld;
    logic          pop_vld;
    logic          cmd_ok;
    logic          mem_we;
    logic [7:0]    mem_waddr;
    logic [7:0]    mem_wdat;
    logic [7:0]    dump_next;
    logic [7:0]    first_byte;

    assign in_cmd        = s_axis_tdata;
    assign s_axis_tready = (state == IDLE) && !dump_pend && (fifo_count < CW'(FIFO_DEPTH));
    assign push_vld      = s_axis_tvalid && s_axis_tready;
    assign busy          = (state != IDLE);

    hist_fifo #(.W($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push_vld (push_vld),
        .push_dat (in_cmd),
        .pop_vld  (pop_vld),
        .head_dat (head_cmd),
        .count    (fifo_count)
    );

    always_comb begin
        pop_vld   = ((state == IDLE) || (state == DRAIN)) && (fifo_count != '0);
        cmd_ok    = (head_cmd.pad_hi == 8'h00) && (head_cmd.pad_lo == 8'h00);
        mem_we    = 1'b0;
        mem_waddr = head_cmd.addr;
        mem_wdat  = head_cmd.data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clear_ptr;
            mem_wdat  = 8'h00;
        end else if (pop_vld && cmd_ok) begin
            mem_we    = 1'b1;
        end
        dump_next  = dump_ptr + 8'd1;
        // The last drained command may target addr 0 on the same edge the dump loads it.
        first_byte = (mem_we && (mem_waddr == 8'h00)) ? mem_wdat : mem[0];
    end

    always_ff @(posedge aclk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdat;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= {24'h0, mem[rd_addr]};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= CLEAR;
            clear_ptr     <= '0;
            dump_ptr      <= '0;
            dump_pend     <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            err_count     <= '0;
        end else begin
            if (pop_vld && !cmd_ok && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            case (state)
                CLEAR: begin
                    clear_ptr <= clear_ptr + 8'd1;
                    if (clear_ptr == LAST_ADDR) state <= IDLE;
                end
                IDLE: begin
                    if (dump_start) begin
                        dump_pend <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // No pushes while draining, so count<=1 means empty after this edge.
                    if (fifo_count <= CW'(1)) begin
                        state         <= DUMP;
                        dump_ptr      <= '0;
                        m_axis_tdata  <= {24'h0, first_byte};
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                    end
                end
                DUMP: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            dump_pend     <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            dump_ptr     <= dump_next;
                            m_axis_tdata <= {8'h00, dump_next, 8'h00, mem[dump_next]};
                            m_axis_tlast <= (dump_next == LAST_ADDR);
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_hist_ram_sink.sv
// Randomized scoreboard bench for hist_ram_sink against a byte-array reference of the RAM.
module tb_hist_ram_sink;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [7:0]  rd_addr = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        dump_start = 1'b0;
    logic        busy;
    logic [7:0]  err_count;

    hist_ram_sink #(.FIFO_DEPTH(4), .MEM_DEPTH(256)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .rd_addr       (rd_addr),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .dump_start    (dump_start),
        .busy          (busy),
        .err_count     (err_count)
    );

    initial forever #5 aclk = ~aclk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          words_seen = 0;
    logic        bp_on = 1'b0;
    logic [7:0]  ref_mem [256];
    int          ref_err = 0;
    logic [31:0] rd_q [$];
    logic [32:0] dump_q [$];

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial forever begin
        @(posedge aclk);
        #1;
        m_axis_tready = bp_on ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Reference: a well-formed word writes its byte, anything else bumps a saturating error count.
    task automatic model_accept(input logic [31:0] w);
        if (w[31:24] == 8'h00 && w[15:8] == 8'h00) ref_mem[w[23:16]] = w[7:0];
        else if (ref_err < 255) ref_err++;
    endtask

    task automatic model_clear();
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
        ref_err = 0;
    endtask

    task automatic send(input logic [31:0] w, output int acc);
        int n = 0;
        acc = -1;
        s_axis_tdata  = w;
        s_axis_tvalid = 1'b1;
        while (acc < 0 && n < 1000) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                @(posedge aclk);
                #1;
                acc = cyc;
                model_accept(w);
            end else begin
                n++;
            end
        end
        s_axis_tvalid = 1'b0;
        if (acc < 0) timeout("send");
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        rd_addr = a;
        rd_en   = 1'b1;
        rd_q.push_back({24'h0, exp});
        @(posedge aclk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic expect_dump();
        for (int a = 0; a < 256; a++) dump_q.push_back({(a == 255), 8'h00, 8'(a), 8'h00, ref_mem[a]});
    endtask

    task automatic wait_dump(input string name);
        int n = 0;
        while (dump_q.size() != 0 && n < 3000) begin
            step(1);
            n++;
        end
        if (dump_q.size() != 0) timeout(name);
    endtask

    // Monitor: pops read and dump expectations when the DUT presents them.
    initial begin
        logic        rd_pend = 1'b0;
        logic        stall_pend = 1'b0;
        logic [32:0] stall_word = '0;
        logic [32:0] exp;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                rd_pend    = 1'b0;
                stall_pend = 1'b0;
                continue;
            end
            if (rd_pend) begin
                if (rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_data: unexpected read result 0x%0h", rd_data);
                end else begin
                    chk("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
                end
            end
            rd_pend = rd_en;
            if (stall_pend) begin
                chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
                chk("stall_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(stall_word));
            end
            stall_pend = m_axis_tvalid && !m_axis_tready;
            stall_word = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                words_seen++;
                if (dump_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dump_extra: unexpected word 0x%0h last=%0b", m_axis_tdata, m_axis_tlast);
                end else begin
                    exp = dump_q.pop_front();
                    chk("dump_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp));
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, n, base;
        logic [7:0] old, ad, dd;
        logic [31:0] w;

        step(3);
        @(negedge aclk);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_err", 64'(err_count), 64'd0);

        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        n = 0;
        @(negedge aclk);
        chk("busy_in_clear", 64'(busy), 64'd1);
        while (!s_axis_tready && n < 2000) begin
            n++;
            @(negedge aclk);
        end
        chk("clear_cycles", 64'(n), 64'd256);
        chk("busy_after_clear", 64'(busy), 64'd0);
        @(posedge aclk);
        #1;
        model_clear();
        rd(8'h00, 8'h00);
        rd(8'h7F, 8'h00);
        rd(8'hFF, 8'h00);

        send(32'h0004_0003, a1);
        send(32'h0041_0055, a2);
        chk("b2b_gap", 64'(a2 - a1), 64'd1);
        step(6);
        rd(8'h04, 8'h03);
        rd(8'h41, 8'h55);
        old = ref_mem[8'h04];
        send(32'h0004_00AA, a1);
        rd(8'h04, old);
        rd(8'h04, 8'hAA);

        send(32'h0110_0077, a1);
        send(32'h0010_7700, a1);
        step(6);
        rd(8'h10, 8'h00);
        chk("err_two", 64'(err_count), 64'd2);
        for (int i = 0; i < 300; i++) begin
            w = {8'($urandom_range(1, 255)), 24'($urandom)};
            send(w, a1);
        end
        step(6);
        chk("err_saturate", 64'(err_count), 64'd255);

        for (int i = 0; i < 40; i++) begin
            ad = 8'($urandom);
            dd = 8'($urandom);
            if ($urandom_range(0, 4) == 0) w = {8'h00, ad, 8'($urandom_range(1, 255)), dd};
            else w = {8'h00, ad, 8'h00, dd};
            send(w, a1);
        end
        step(6);
        for (int i = 0; i < 20; i++) begin
            ad = 8'($urandom);
            rd(ad, ref_mem[ad]);
        end
        chk("err_random", 64'(err_count), 64'(ref_err));

        send(32'h0020_0011, a1);
        send(32'h0021_0022, a1);
        send(32'h00FF_00EE, a1);
        dump_start = 1'b1;
        send(32'h0000_005A, a1);
        dump_start = 1'b0;
        expect_dump();
        @(negedge aclk);
        chk("tready_on_dump", 64'(s_axis_tready), 64'd0);
        @(posedge aclk);
        #1;
        wait_dump("dump_order");
        step(4);
        chk("dump_order_idle", 64'(m_axis_tvalid), 64'd0);
        chk("dump_order_busy", 64'(busy), 64'd0);

        bp_on = 1'b1;
        dump_start = 1'b1;
        step(1);
        dump_start = 1'b0;
        expect_dump();
        n = 0;
        while (dump_q.size() != 0 && n < 3000) begin
            step(1);
            dump_start = ((n % 37) == 5);
            n++;
        end
        dump_start = 1'b0;
        bp_on = 1'b0;
        if (dump_q.size() != 0) timeout("dump_bp");
        step(10);
        chk("dump_bp_idle", 64'(m_axis_tvalid), 64'd0);

        dump_start = 1'b1;
        step(1);
        dump_start = 1'b0;
        expect_dump();
        base = words_seen;
        n = 0;
        while (words_seen < base + 100 && n < 2000) begin
            step(1);
            n++;
        end
        if (words_seen < base + 100) timeout("mid_dump_wait");
        aresetn = 1'b0;
        #1;
        chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("reset_tlast", 64'(m_axis_tlast), 64'd0);
        dump_q.delete();
        rd_q.delete();
        step(3);
        aresetn = 1'b1;
        step(2);
        dump_start = 1'b1;
        step(1);
        dump_start = 1'b0;
        n = 0;
        while (!s_axis_tready && n < 400) begin
            step(1);
            n++;
        end
        chk("reclear_ready", 64'(s_axis_tready), 64'd1);
        model_clear();
        chk("reclear_err", 64'(err_count), 64'(ref_err));
        rd(8'h00, ref_mem[8'h00]);
        rd(8'h04, ref_mem[8'h04]);
        rd(8'h41, ref_mem[8'h41]);
        rd(8'h7F, ref_mem[8'h7F]);
        rd(8'hFF, ref_mem[8'hFF]);
        for (int i = 0; i < 8; i++) begin
            ad = 8'($urandom);
            rd(ad, ref_mem[ad]);
        end
        step(20);
        chk("reclear_no_dump", 64'(m_axis_tvalid), 64'd0);
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
